// File: rtl/ldl_fifo_ws_v2_pkg.sv
// Shared pointer arithmetic for the FIFO write and read controllers.
// Values are carried at a fixed 32-bit width and masked to the pointer width.
package ldl_fifo_pkg;

  localparam int unsigned PTR_W_MAX = 32;

  typedef logic [PTR_W_MAX-1:0] ptr_t;

  // Occupancy between two extended pointers, modulo 2**(aw+1).
  function automatic ptr_t ptr_cnt(input ptr_t w, input ptr_t r, input int unsigned aw);
    ptr_t mask_v;
    mask_v = (32'd1 << (aw + 32'd1)) - 32'd1;
    return (w - r) & mask_v;
  endfunction

  // Free entries left for a given occupancy in a 2**aw deep FIFO.
  function automatic ptr_t free_cnt(input ptr_t cnt, input int unsigned aw);
    return (32'd1 << aw) - cnt;
  endfunction

endpackage

// File: rtl/ldl_fifo_ws_v2_if.sv
// Producer-side write port: request and per-lane RAM write strobes/addresses.
interface ldl_fifo_ws_v2_if #(
  parameter int AW = 8,
  parameter int WN = 4,
  parameter int CW = $clog2(WN + 1)
) ();

  logic              we;
  logic [CW-1:0]     wn;
  logic              wacc;
  logic [WN-1:0]     mw;
  logic [WN*AW-1:0]  wa;

  modport master (output we, output wn, input wacc, input mw, input wa);
  modport slave  (input we, input wn, output wacc, output mw, output wa);

endinterface

// File: rtl/ldl_fifo_lane_addr.sv
// Per-lane RAM addresses (wrapping modulo the depth) and write strobes
// for a multi-word write starting at the base pointer.
module ldl_fifo_lane_addr #(
  parameter int AW = 8,
  parameter int WN = 4,
  parameter int CW = $clog2(WN + 1)
) (
  input  logic [AW:0]       base,
  input  logic [CW-1:0]     wn,
  input  logic              acc,
  output logic [WN-1:0]     mw,
  output logic [WN*AW-1:0]  wa
);

  // Lane i writes base+i; only the first wn lanes strobe, and only when accepted.
  always_comb begin
    mw = {WN{1'b0}};
    wa = {(WN*AW){1'b0}};
    for (int i = 0; i < WN; i++) begin
      wa[i*AW +: AW] = base[AW-1:0] + AW'(i);
      mw[i]          = acc & (CW'(i) < wn);
    end
  end

endmodule

// File: rtl/ldl_fifo_ws_v2.sv
// Write-side pointer controller: all-or-nothing multi-word acceptance,
// lane strobes/addresses, fill level, free space, full/almost-full flags
// and a sticky overflow flag.
module ldl_fifo_ws_v2
  import ldl_fifo_pkg::*;
#(
  parameter int AW        = 8,
  parameter int WN        = 4,
  parameter int REG_FLAGS = 0,
  parameter int CW        = $clog2(WN + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  ldl_fifo_ws_v2_if.slave      wr,
  input  logic [AW:0]          r_pt,
  output logic [AW:0]          w_pt,
  output logic [AW:0]          wcnt,
  output logic [AW:0]          free,
  input  logic [AW:0]          afull_th,
  output logic                 full,
  output logic                 afull,
  output logic                 ovf,
  input  logic                 ovf_clr
);

  logic [AW:0] w_pt_r;
  logic [AW:0] w_pt_nxt_s;
  ptr_t        cnt_s;
  ptr_t        free_s;
  ptr_t        cnt_nxt_s;
  logic        req_s;
  logic        fit_s;
  logic        wacc_s;
  logic        rej_s;
  logic        full_c_s;
  logic        afull_c_s;
  logic        full_nxt_s;
  logic        afull_nxt_s;
  logic        ovf_r;
  logic        full_r;
  logic        afull_r;

  // Occupancy, acceptance and next pointer; reset suppresses any write.
  always_comb begin
    cnt_s       = ptr_cnt(32'(w_pt_r), 32'(r_pt), AW);
    free_s      = free_cnt(cnt_s, AW);
    req_s       = wr.we & (wr.wn != {CW{1'b0}});
    fit_s       = (32'(wr.wn) <= free_s);
    wacc_s      = ~rst & req_s & fit_s;
    rej_s       = ~rst & req_s & ~fit_s;
    full_c_s    = (w_pt_r[AW] != r_pt[AW]) & (w_pt_r[AW-1:0] == r_pt[AW-1:0]);
    afull_c_s   = (cnt_s >= 32'(afull_th));
    if (wacc_s) begin
      w_pt_nxt_s = w_pt_r + (AW+1)'(wr.wn);
    end else begin
      w_pt_nxt_s = w_pt_r;
    end
    cnt_nxt_s   = ptr_cnt(32'(w_pt_nxt_s), 32'(r_pt), AW);
    full_nxt_s  = (w_pt_nxt_s[AW] != r_pt[AW]) & (w_pt_nxt_s[AW-1:0] == r_pt[AW-1:0]);
    afull_nxt_s = (cnt_nxt_s >= 32'(afull_th));
  end

  // Pointer, sticky overflow (set wins over clear) and look-ahead flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_pt_r  <= {(AW+1){1'b0}};
      ovf_r   <= 1'b0;
      full_r  <= 1'b0;
      afull_r <= 1'b0;
    end else begin
      w_pt_r  <= w_pt_nxt_s;
      full_r  <= full_nxt_s;
      afull_r <= afull_nxt_s;
      if (rej_s) begin
        ovf_r <= 1'b1;
      end else if (ovf_clr) begin
        ovf_r <= 1'b0;
      end else begin
        ovf_r <= ovf_r;
      end
    end
  end

  ldl_fifo_lane_addr #(.AW(AW), .WN(WN), .CW(CW)) u_lane_addr (
    .base (w_pt_r),
    .wn   (wr.wn),
    .acc  (wacc_s),
    .mw   (wr.mw),
    .wa   (wr.wa)
  );

  assign wr.wacc = wacc_s;
  assign w_pt    = w_pt_r;
  assign wcnt    = cnt_s[AW:0];
  assign free    = free_s[AW:0];
  assign ovf     = ovf_r;
  assign full    = (REG_FLAGS != 0) ? full_r  : full_c_s;
  assign afull   = (REG_FLAGS != 0) ? afull_r : afull_c_s;

endmodule

// File: tb/tb_ldl_fifo_ws_v2.sv
// Bench for ldl_fifo_ws_v2 (AW=3, WN=4): directed vector table and random
// traffic against an occupancy model on a combinational-flag instance, plus
// hand-written sequences on a registered-flag instance.
module tb_ldl_fifo_ws_v2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Instance 0: REG_FLAGS = 0
  logic       rst0, clr0;
  logic [3:0] rpt0, th0, wpt0, wcnt0, free0;
  logic       full0, afull0, ovf0;
  ldl_fifo_ws_v2_if #(.AW(3), .WN(4)) if0 ();
  ldl_fifo_ws_v2 #(.AW(3), .WN(4), .REG_FLAGS(0)) dut0 (
    .clk(clk), .rst(rst0), .wr(if0), .r_pt(rpt0), .w_pt(wpt0), .wcnt(wcnt0),
    .free(free0), .afull_th(th0), .full(full0), .afull(afull0), .ovf(ovf0),
    .ovf_clr(clr0));

  // Instance 1: REG_FLAGS = 1
  logic       rst1, clr1;
  logic [3:0] rpt1, th1, wpt1, wcnt1, free1;
  logic       full1, afull1, ovf1;
  ldl_fifo_ws_v2_if #(.AW(3), .WN(4)) if1 ();
  ldl_fifo_ws_v2 #(.AW(3), .WN(4), .REG_FLAGS(1)) dut1 (
    .clk(clk), .rst(rst1), .wr(if1), .r_pt(rpt1), .w_pt(wpt1), .wcnt(wcnt1),
    .free(free1), .afull_th(th1), .full(full1), .afull(afull1), .ovf(ovf1),
    .ovf_clr(clr1));

  typedef struct {
    logic       we;
    logic [2:0] wn;
    logic [3:0] rpt;
    logic       clr;
    logic [3:0] wpt, wcnt, free;
    logic       full, afull, ovf, wacc;
    logic [3:0] mw;
    logic [11:0] wa;
  } vec_t;

  vec_t vt[15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] pk(input int a0, input int a1, input int a2, input int a3);
    logic [2:0] b0, b1, b2, b3;
    b0 = 3'(a0); b1 = 3'(a1); b2 = 3'(a2); b3 = 3'(a3);
    return {b3, b2, b1, b0};
  endfunction

  function automatic vec_t mk(input logic we, input int wn, input int rpt, input logic clr,
                              input int wpt, input int wcnt, input int free,
                              input logic full, input logic afull, input logic ovf,
                              input logic wacc, input logic [3:0] mw, input logic [11:0] wa);
    vec_t v;
    v.we = we; v.wn = 3'(wn); v.rpt = 4'(rpt); v.clr = clr;
    v.wpt = 4'(wpt); v.wcnt = 4'(wcnt); v.free = 4'(free);
    v.full = full; v.afull = afull; v.ovf = ovf; v.wacc = wacc; v.mw = mw; v.wa = wa;
    return v;
  endfunction

  // Behavioural model state for random traffic
  int m_wp, m_rp, m_cnt, m_free;
  logic m_ovf;

  initial begin
    logic [3:0]  e_mw;
    logic [11:0] e_wa;
    logic        e_acc;
    int          r_we, r_wn, r_th;
    logic        r_clr;

    // Directed vectors (afull_th = 6); state carries from row to row.
    vt[0]  = mk(1'b0, 0,  0, 1'b0,  0, 0, 8, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, pk(0,1,2,3));
    vt[1]  = mk(1'b1, 3,  0, 1'b0,  0, 0, 8, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0111, pk(0,1,2,3));
    vt[2]  = mk(1'b1, 3,  0, 1'b0,  3, 3, 5, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0111, pk(3,4,5,6));
    vt[3]  = mk(1'b1, 3,  0, 1'b0,  6, 6, 2, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, pk(6,7,0,1));
    vt[4]  = mk(1'b1, 2,  0, 1'b0,  6, 6, 2, 1'b0, 1'b1, 1'b1, 1'b1, 4'b0011, pk(6,7,0,1));
    vt[5]  = mk(1'b0, 0,  0, 1'b0,  8, 8, 0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, pk(0,1,2,3));
    vt[6]  = mk(1'b1, 1,  0, 1'b1,  8, 8, 0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, pk(0,1,2,3));
    vt[7]  = mk(1'b0, 0,  0, 1'b0,  8, 8, 0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, pk(0,1,2,3));
    vt[8]  = mk(1'b0, 0,  0, 1'b1,  8, 8, 0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, pk(0,1,2,3));
    vt[9]  = mk(1'b1, 0,  0, 1'b0,  8, 8, 0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, pk(0,1,2,3));
    vt[10] = mk(1'b0, 0,  8, 1'b0,  8, 0, 8, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, pk(0,1,2,3));
    vt[11] = mk(1'b1, 4,  8, 1'b0,  8, 0, 8, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1111, pk(0,1,2,3));
    vt[12] = mk(1'b1, 2,  8, 1'b0, 12, 4, 4, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0011, pk(4,5,6,7));
    vt[13] = mk(1'b1, 4, 12, 1'b0, 14, 2, 6, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1111, pk(6,7,0,1));
    vt[14] = mk(1'b0, 0, 12, 1'b0,  2, 6, 2, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, pk(2,3,4,5));

    rst0 = 1'b1; clr0 = 1'b0; rpt0 = 4'd0; th0 = 4'd6; if0.we = 1'b0; if0.wn = 3'd0;
    rst1 = 1'b1; clr1 = 1'b0; rpt1 = 4'd0; th1 = 4'd6; if1.we = 1'b0; if1.wn = 3'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst0 = 1'b0; rst1 = 1'b0;
    #2;
    chk("rst_wpt", 32'(wpt0), 32'd0);
    chk("rst_wcnt", 32'(wcnt0), 32'd0);
    chk("rst_free", 32'(free0), 32'd8);
    chk("rst_full", 32'(full0), 32'd0);
    chk("rst_afull", 32'(afull0), 32'd0);
    chk("rst_ovf", 32'(ovf0), 32'd0);
    chk("rst_mw", 32'(if0.mw), 32'd0);
    chk("rst_full_reg", 32'(full1), 32'd0);
    chk("rst_afull_reg", 32'(afull1), 32'd0);

    // Table-driven directed vectors
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if0.we = vt[k].we; if0.wn = vt[k].wn; rpt0 = vt[k].rpt; clr0 = vt[k].clr;
      #2;
      chk($sformatf("v%0d_wpt", k), 32'(wpt0), 32'(vt[k].wpt));
      chk($sformatf("v%0d_wcnt", k), 32'(wcnt0), 32'(vt[k].wcnt));
      chk($sformatf("v%0d_free", k), 32'(free0), 32'(vt[k].free));
      chk($sformatf("v%0d_full", k), 32'(full0), 32'(vt[k].full));
      chk($sformatf("v%0d_afull", k), 32'(afull0), 32'(vt[k].afull));
      chk($sformatf("v%0d_ovf", k), 32'(ovf0), 32'(vt[k].ovf));
      chk($sformatf("v%0d_wacc", k), 32'(if0.wacc), 32'(vt[k].wacc));
      chk($sformatf("v%0d_mw", k), 32'(if0.mw), 32'(vt[k].mw));
      chk($sformatf("v%0d_wa", k), 32'(if0.wa), 32'(vt[k].wa));
    end

    // Random traffic against the occupancy model
    @(negedge clk);
    rst0 = 1'b1; if0.we = 1'b0; if0.wn = 3'd0; rpt0 = 4'd0; clr0 = 1'b0;
    @(negedge clk);
    rst0 = 1'b0;
    m_wp = 0; m_rp = 0; m_ovf = 1'b0;
    for (int c = 0; c < 400; c++) begin
      m_cnt = (m_wp - m_rp) & 15;
      if ($urandom_range(0, 3) == 0) m_rp = (m_rp + int'($urandom_range(0, m_cnt))) & 15;
      m_cnt  = (m_wp - m_rp) & 15;
      m_free = 8 - m_cnt;
      r_we   = int'($urandom_range(0, 3) != 0);
      r_wn   = int'($urandom_range(0, 4));
      r_clr  = ($urandom_range(0, 7) == 0);
      r_th   = int'($urandom_range(0, 8));
      if0.we = r_we[0]; if0.wn = 3'(r_wn); rpt0 = 4'(m_rp); clr0 = r_clr; th0 = 4'(r_th);
      #2;
      e_acc = (r_we != 0) && (r_wn != 0) && (r_wn <= m_free);
      for (int i = 0; i < 4; i++) begin
        e_mw[i] = e_acc && (i < r_wn);
        e_wa[i*3 +: 3] = 3'((m_wp + i) % 8);
      end
      chk("rnd_wacc", 32'(if0.wacc), 32'(e_acc));
      chk("rnd_mw", 32'(if0.mw), 32'(e_mw));
      chk("rnd_wa", 32'(if0.wa), 32'(e_wa));
      chk("rnd_wpt", 32'(wpt0), 32'(m_wp));
      chk("rnd_wcnt", 32'(wcnt0), 32'(m_cnt));
      chk("rnd_free", 32'(free0), 32'(m_free));
      chk("rnd_full", 32'(full0), 32'(m_cnt == 8));
      chk("rnd_afull", 32'(afull0), 32'(m_cnt >= r_th));
      chk("rnd_ovf", 32'(ovf0), 32'(m_ovf));
      if (e_acc) m_wp = (m_wp + r_wn) & 15;
      if ((r_we != 0) && (r_wn != 0) && !e_acc) m_ovf = 1'b1;
      else if (r_clr) m_ovf = 1'b0;
      @(negedge clk);
    end

    // Registered flags: look-ahead assertion, lagging deassertion, reset
    @(negedge clk);
    if1.we = 1'b1; if1.wn = 3'd4; rpt1 = 4'd0;
    #2 chk("rf_wacc0", 32'(if1.wacc), 32'd1);
    @(negedge clk);
    #2;
    chk("rf_wpt4", 32'(wpt1), 32'd4);
    chk("rf_full_at4", 32'(full1), 32'd0);
    chk("rf_wacc1", 32'(if1.wacc), 32'd1);
    @(negedge clk);
    if1.we = 1'b0; if1.wn = 3'd0; rpt1 = 4'd1;
    #2;
    chk("rf_wpt8", 32'(wpt1), 32'd8);
    chk("rf_full_read_cycle", 32'(full1), 32'd1);
    chk("rf_afull_at8", 32'(afull1), 32'd1);
    chk("rf_free_comb", 32'(free1), 32'd1);
    @(negedge clk);
    if1.we = 1'b1; if1.wn = 3'd1;
    #2;
    chk("rf_full_after_read", 32'(full1), 32'd0);
    chk("rf_wacc_after_read", 32'(if1.wacc), 32'd1);
    @(negedge clk);
    #2;
    chk("rf_wpt9", 32'(wpt1), 32'd9);
    chk("rf_full_refill", 32'(full1), 32'd1);
    chk("rf_ovf_reject", 32'(if1.wacc), 32'd0);
    @(negedge clk);
    #2 chk("rf_ovf_set", 32'(ovf1), 32'd1);
    rst1 = 1'b1; if1.we = 1'b1; if1.wn = 3'd4; rpt1 = 4'd9;
    #1;
    chk("rf_rst_mw", 32'(if1.mw), 32'd0);
    chk("rf_rst_wacc", 32'(if1.wacc), 32'd0);
    @(negedge clk);
    rst1 = 1'b0; if1.we = 1'b0; if1.wn = 3'd0; rpt1 = 4'd0;
    #2;
    chk("rf_rst_wpt", 32'(wpt1), 32'd0);
    chk("rf_rst_full", 32'(full1), 32'd0);
    chk("rf_rst_ovf", 32'(ovf1), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
